// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: one shared char-to-segment decoder,
// anti-ghosting dead time between digits, frame-aligned double-buffered updates.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int DWELL      = 1000,
    parameter int DEAD       = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [4*NUM_DIGITS-1:0] wr_data,
    input  logic                    blank_lz,
    output logic                    wr_ready,
    output logic [3:0]              char,
    input  logic [6:0]              seg_dec,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    frame_done
);

    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_MAX = (DWELL > DEAD) ? DWELL : DEAD;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] DEAD_END = CNT_W'(DEAD - 1);
    localparam logic [CNT_W-1:0] ON_END   = CNT_W'(DWELL - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DEAD,
        S_ON
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [4*NUM_DIGITS-1:0] active_q;
    logic [4*NUM_DIGITS-1:0] pending_q;
    logic                    pending_valid_q;
    logic [6:0]              seg_hold_q;

    logic       wr_accept;
    logic       dead_end;
    logic       on_end;
    logic       frame_wrap;
    logic [3:0] nib_raw;
    logic [3:0] nib_eff;
    logic       upper_zero;

    assign wr_accept  = wr_en && wr_ready;
    assign dead_end   = (state_q == S_DEAD) && (cnt_q == DEAD_END);
    assign on_end     = (state_q == S_ON) && (cnt_q == ON_END);
    assign frame_wrap = on_end && (idx_q == LAST_IDX);

    // NOTE: every always_comb output gets a default before any branch, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (wr_accept) begin
                    state_d = S_DEAD;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            end
            S_DEAD: begin
                if (cnt_q == DEAD_END) begin
                    state_d = S_ON;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_ON: begin
                if (cnt_q == ON_END) begin
                    state_d = S_DEAD;
                    cnt_d   = '0;
                    idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: the display values are reset too, because a reset must discard
    // both the shown and the queued value rather than leave stale data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q        <= '0;
            pending_q       <= '0;
            pending_valid_q <= 1'b0;
            seg_hold_q      <= 7'h7F;
        end else begin
            if (state_q == S_IDLE && wr_accept) begin
                active_q <= wr_data;
            end
            // Swap only at the frame boundary so a frame never mixes two values.
            if (frame_wrap && pending_valid_q) begin
                active_q        <= pending_q;
                pending_valid_q <= 1'b0;
            end else if (state_q != S_IDLE && wr_accept) begin
                pending_q       <= wr_data;
                pending_valid_q <= 1'b1;
            end
            if (dead_end) begin
                seg_hold_q <= seg_dec;
            end
        end
    end

    // A digit blanks when it and every more-significant digit are zero.
    always_comb begin
        nib_raw    = 4'h0;
        upper_zero = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (k == int'(idx_q)) begin
                nib_raw = active_q[4*k +: 4];
            end
            if (k >= int'(idx_q) && active_q[4*k +: 4] != 4'h0) begin
                upper_zero = 1'b0;
            end
        end
        nib_eff = (blank_lz && idx_q != '0 && upper_zero) ? 4'hF : nib_raw;
    end

    always_comb begin
        wr_ready   = !pending_valid_q;
        frame_done = frame_wrap;
        char       = (state_q == S_IDLE) ? 4'h0 : nib_eff;
        seg        = (state_q == S_ON) ? seg_hold_q : 7'h7F;
        an_n       = '1;
        if (state_q == S_ON) begin
            an_n[idx_q] = 1'b0;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl (DWELL=4, DEAD=2, NUM_DIGITS=4) with a
// stub active-low hex decoder that blanks codes A-F.
module tb_seg_scan_ctrl;

    localparam int ND = 4;
    localparam int DW = 4;
    localparam int DD = 2;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b1;
    logic          wr_en    = 1'b0;
    logic [15:0]   wr_data  = '0;
    logic          blank_lz = 1'b0;
    logic          wr_ready;
    logic [3:0]    char;
    logic [6:0]    seg_dec;
    logic [6:0]    seg;
    logic [ND-1:0] an_n;
    logic          frame_done;

    int         tests = 0;
    int         fails = 0;
    logic [6:0] first_on_seg;

    always #5 clk = ~clk;

    function automatic logic [6:0] dec7(input logic [3:0] c);
        case (c)
            4'h0: dec7 = 7'h40;
            4'h1: dec7 = 7'h79;
            4'h2: dec7 = 7'h24;
            4'h3: dec7 = 7'h30;
            4'h4: dec7 = 7'h19;
            4'h5: dec7 = 7'h12;
            4'h6: dec7 = 7'h02;
            4'h7: dec7 = 7'h78;
            4'h8: dec7 = 7'h00;
            4'h9: dec7 = 7'h10;
            default: dec7 = 7'h7F;
        endcase
    endfunction

    assign seg_dec = dec7(char);

    seg_scan_ctrl #(
        .NUM_DIGITS(ND),
        .DWELL     (DW),
        .DEAD      (DD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .blank_lz  (blank_lz),
        .wr_ready  (wr_ready),
        .char      (char),
        .seg_dec   (seg_dec),
        .seg       (seg),
        .an_n      (an_n),
        .frame_done(frame_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // At most one digit enabled, every cycle.
    always @(negedge clk) begin
        check("an_n_onehot0", 32'($countones(~an_n) <= 1), 32'd1);
    end

    task automatic step();
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic check_blank(input string tag);
        check({tag, "_an_n"}, an_n, 4'hF);
        check({tag, "_seg"}, seg, 7'h7F);
        check({tag, "_char"}, char, 4'h0);
        check({tag, "_frame_done"}, frame_done, 1'b0);
        check({tag, "_wr_ready"}, wr_ready, 1'b1);
    endtask

    task automatic do_slot(input int d, input logic [3:0] ch, input bit inj_start,
                           input bit inj_end, input logic [15:0] inj);
        logic [3:0] exp_an;
        exp_an = ~(4'b0001 << d);
        if (inj_start) begin
            wr_en   = 1'b1;
            wr_data = inj;
        end
        for (int i = 0; i < DD; i++) begin
            check($sformatf("dead_d%0d_c%0d_an_n", d, i), an_n, 4'hF);
            check($sformatf("dead_d%0d_c%0d_seg", d, i), seg, 7'h7F);
            check($sformatf("dead_d%0d_c%0d_char", d, i), char, ch);
            check($sformatf("dead_d%0d_c%0d_frame_done", d, i), frame_done, 1'b0);
            step();
            if (inj_start && i == 0) begin
                check($sformatf("wr_ready_drop_d%0d", d), wr_ready, 1'b0);
            end
        end
        for (int i = 0; i < DW; i++) begin
            if (d == 0 && i == 0) first_on_seg = seg;
            check($sformatf("on_d%0d_c%0d_an_n", d, i), an_n, exp_an);
            check($sformatf("on_d%0d_c%0d_seg", d, i), seg, dec7(ch));
            check($sformatf("on_d%0d_c%0d_char", d, i), char, ch);
            check($sformatf("on_d%0d_c%0d_frame_done", d, i), frame_done,
                  (d == ND - 1 && i == DW - 1) ? 1'b1 : 1'b0);
            if (inj_end && i == DW - 1) begin
                check("wr_ready_at_wrap", wr_ready, 1'b1);
                wr_en   = 1'b1;
                wr_data = inj;
            end
            step();
        end
    endtask

    // chars: expected effective nibble per digit, digit 0 in bits [3:0].
    task automatic do_frame(input logic [15:0] chars, input int inj_digit,
                            input bit inj_wrap, input logic [15:0] inj);
        for (int d = 0; d < ND; d++) begin
            do_slot(d, chars[4*d +: 4], inj_digit == d, inj_wrap && d == ND - 1, inj);
        end
    endtask

    initial begin
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_blank("in_reset");
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            check_blank($sformatf("idle%0d", i));
            step();
        end

        // Frame A shows 1234; 5678 written mid-frame goes pending.
        wr_en   = 1'b1;
        wr_data = 16'h1234;
        step();
        do_frame(16'h1234, 1, 1'b0, 16'h5678);
        check("digit0_code_for_4", first_on_seg, 7'b0011001);
        check("wr_ready_after_wrap_A", wr_ready, 1'b1);

        // Frame B shows 5678; write landing in the wrap cycle waits a frame.
        do_frame(16'h5678, -1, 1'b1, 16'h0040);
        check("wr_ready_held_after_B", wr_ready, 1'b0);

        blank_lz = 1'b1;
        do_frame(16'h5678, -1, 1'b0, 16'h0000);
        check("wr_ready_after_wrap_C", wr_ready, 1'b1);

        // 0040 with leading-zero blanking: digits 3,2 blank.
        do_frame(16'hFF40, -1, 1'b0, 16'h0000);

        blank_lz = 1'b0;
        do_frame(16'h0040, 0, 1'b0, 16'hA000);
        check("wr_ready_after_wrap_E", wr_ready, 1'b1);

        // A000 with blanking: nonzero top digit keeps inner zeros; A passes through.
        blank_lz = 1'b1;
        do_frame(16'hA000, -1, 1'b0, 16'h0000);

        // Reset in ON of digit 2 with a value pending.
        do_slot(0, 4'h0, 1'b1, 1'b0, 16'h9999);
        do_slot(1, 4'h0, 1'b0, 1'b0, 16'h0000);
        step();
        step();
        step();
        check("pre_reset_an_n", an_n, 4'hB);
        check("pre_reset_wr_ready", wr_ready, 1'b0);
        rst_n = 1'b0;
        #1;
        check_blank("async_reset");
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check_blank($sformatf("post_reset_idle%0d", i));
            step();
        end

        // Fresh write after reset; stale pending value must not appear.
        wr_en   = 1'b1;
        wr_data = 16'h0007;
        step();
        do_frame(16'hFFF7, -1, 1'b0, 16'h0000);
        check("wr_ready_final", wr_ready, 1'b1);
        do_frame(16'hFFF7, -1, 1'b0, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
